// File: rtl/quad_filter.sv
// Input conditioning for the quadrature counter: synchronizers, glitch filters and an illegal-transition monitor.
// Define QUAD_FILTER_Z_EN to give Z its own glitch filter; otherwise Zf is the synchronized Z.
module quad_filter #(
    parameter int FILT_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              A,
    input  logic              B,
    input  logic              Z,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              err_clr,
    output logic              Af,
    output logic              Bf,
    output logic              Zf,
    output logic              err,
    output logic [7:0]        err_cnt
);

`ifdef QUAD_FILTER_Z_EN
    localparam int NF = 3;
`else
    localparam int NF = 2;
`endif

    localparam logic [FILT_W-1:0] CNT_ZERO = {FILT_W{1'b0}};
    localparam logic [FILT_W-1:0] CNT_ONE  = FILT_W'(1'b1);
    localparam logic [7:0]        ERR_MAX  = 8'd255;

    logic [2:0]                    raw_s;
    logic [2:0][SYNC_STAGES-1:0]   sync_r;
    logic [2:0]                    s_s;
    logic [SYNC_STAGES-1:0]        prime_r;
    logic                          primed_s;

    logic [NF-1:0]                 filt_r;
    logic [NF-1:0]                 filt_nxt_s;
    logic [NF-1:0][FILT_W-1:0]     cnt_r;
    logic [NF-1:0][FILT_W-1:0]     cnt_nxt_s;

    logic                          af_d_r;
    logic                          bf_d_r;
    logic                          armed_r;
    logic                          armed_nxt_s;
    logic                          illegal_s;
    logic                          err_r;
    logic                          err_nxt_s;
    logic [7:0]                    err_cnt_r;
    logic [7:0]                    err_cnt_nxt_s;

    assign raw_s = {Z, B, A};

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            s_s[c] = sync_r[c][SYNC_STAGES-1];
        end
    end

    // prime_r marks when the synchronizers hold post-reset pin samples, so the
    // reset-cleared zeros cannot arm the monitor while the pins are still high.
    assign primed_s    = prime_r[SYNC_STAGES-1];
    assign armed_nxt_s = armed_r | (primed_s & (filt_r[0] == s_s[0]) & (filt_r[1] == s_s[1]));
    assign illegal_s   = armed_r & (filt_r[0] ^ af_d_r) & (filt_r[1] ^ bf_d_r);

    // Synchronizer chains, filter state, arming and previous-output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r  <= {(3*SYNC_STAGES){1'b0}};
            prime_r <= {SYNC_STAGES{1'b0}};
            filt_r  <= {NF{1'b0}};
            cnt_r   <= {(NF*FILT_W){1'b0}};
            af_d_r  <= 1'b0;
            bf_d_r  <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                sync_r[c] <= {sync_r[c][SYNC_STAGES-2:0], raw_s[c]};
            end
            prime_r <= {prime_r[SYNC_STAGES-2:0], 1'b1};
            filt_r  <= filt_nxt_s;
            cnt_r   <= cnt_nxt_s;
            af_d_r  <= filt_r[0];
            bf_d_r  <= filt_r[1];
            armed_r <= armed_nxt_s;
        end
    end

    // Glitch filter next state: idle, keep counting, or accept the new level.
    always_comb begin
        filt_nxt_s = filt_r;
        cnt_nxt_s  = cnt_r;
        for (int c = 0; c < NF; c++) begin
            if (s_s[c] == filt_r[c]) begin
                cnt_nxt_s[c] = CNT_ZERO;
            end else if (cnt_r[c] >= filt_len) begin
                filt_nxt_s[c] = s_s[c];
                cnt_nxt_s[c]  = CNT_ZERO;
            end else begin
                cnt_nxt_s[c] = cnt_r[c] + CNT_ONE;
            end
        end
    end

    // Error bookkeeping; an illegal edge in the same cycle outranks err_clr.
    always_comb begin
        err_nxt_s     = err_r;
        err_cnt_nxt_s = err_cnt_r;
        if (illegal_s) begin
            err_nxt_s = 1'b1;
            if (err_clr) begin
                err_cnt_nxt_s = 8'd1;
            end else if (err_cnt_r != ERR_MAX) begin
                err_cnt_nxt_s = err_cnt_r + 8'd1;
            end else begin
                err_cnt_nxt_s = err_cnt_r;
            end
        end else if (err_clr) begin
            err_nxt_s     = 1'b0;
            err_cnt_nxt_s = 8'd0;
        end else begin
            err_nxt_s     = err_r;
            err_cnt_nxt_s = err_cnt_r;
        end
    end

    // Error flag and saturating count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r     <= 1'b0;
            err_cnt_r <= 8'd0;
        end else begin
            err_r     <= err_nxt_s;
            err_cnt_r <= err_cnt_nxt_s;
        end
    end

    assign Af      = filt_r[0];
    assign Bf      = filt_r[1];
`ifdef QUAD_FILTER_Z_EN
    assign Zf      = filt_r[2];
`else
    assign Zf      = s_s[2];
`endif
    assign err     = err_r;
    assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_quad_filter.sv
// Directed, table-driven bench for quad_filter (default parameters), plus hand-written multi-cycle sequences.
module tb_quad_filter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       A = 1'b0;
    logic       B = 1'b0;
    logic       Z = 1'b0;
    logic [3:0] filt_len = 4'd3;
    logic       err_clr = 1'b0;
    logic       Af;
    logic       Bf;
    logic       Zf;
    logic       err;
    logic [7:0] err_cnt;

    int checks = 0;
    int failures = 0;

    quad_filter dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .Z        (Z),
        .filt_len (filt_len),
        .err_clr  (err_clr),
        .Af       (Af),
        .Bf       (Bf),
        .Zf       (Zf),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       a;
        logic       b;
        logic       z;
        logic [3:0] fl;
        logic       clr;
        logic       eaf;
        logic       ebf;
        logic       ezf;
        logic       eerr;
        logic [7:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic rst, input logic a, input logic b, input logic z,
                       input logic [3:0] fl, input logic clr, input logic eaf, input logic ebf,
                       input logic ezf, input logic eerr, input logic [7:0] ecnt);
        vec_t v;
        v.rst = rst; v.a = a; v.b = b; v.z = z; v.fl = fl; v.clr = clr;
        v.eaf = eaf; v.ebf = ebf; v.ezf = ezf; v.eerr = eerr; v.ecnt = ecnt;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int zlat;

    initial begin
        // Reset, latency and glitch rejection with filt_len=3.
        add(2, 1, 0, 0, 0, 4'd3, 0, 0, 0, 0, 0, 8'd0);
        add(3, 0, 0, 0, 0, 4'd3, 0, 0, 0, 0, 0, 8'd0);
        add(5, 0, 1, 0, 0, 4'd3, 0, 0, 0, 0, 0, 8'd0);
        add(3, 0, 1, 0, 0, 4'd3, 0, 1, 0, 0, 0, 8'd0);
        add(5, 0, 0, 0, 0, 4'd3, 0, 1, 0, 0, 0, 8'd0);
        add(3, 0, 0, 0, 0, 4'd3, 0, 0, 0, 0, 0, 8'd0);
        add(3, 0, 1, 0, 0, 4'd3, 0, 0, 0, 0, 0, 8'd0);
        add(6, 0, 0, 0, 0, 4'd3, 0, 0, 0, 0, 0, 8'd0);
        add(4, 0, 1, 0, 0, 4'd3, 0, 0, 0, 0, 0, 8'd0);
        add(1, 0, 0, 0, 0, 4'd3, 0, 0, 0, 0, 0, 8'd0);
        add(4, 0, 0, 0, 0, 4'd3, 0, 1, 0, 0, 0, 8'd0);
        add(3, 0, 0, 0, 0, 4'd3, 0, 0, 0, 0, 0, 8'd0);
        // Illegal transition with filt_len=0.
        add(2, 0, 1, 1, 0, 4'd0, 0, 0, 0, 0, 0, 8'd0);
        add(1, 0, 1, 1, 0, 4'd0, 0, 1, 1, 0, 0, 8'd0);
        add(2, 0, 1, 1, 0, 4'd0, 0, 1, 1, 0, 1, 8'd1);
        add(2, 0, 0, 0, 0, 4'd0, 0, 1, 1, 0, 1, 8'd1);
        add(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1, 8'd1);
        add(2, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1, 8'd2);
        add(1, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0, 0, 8'd0);
        add(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 8'd0);
        // Five back-to-back illegal edges bring err_cnt to 5.
        add(1, 0, 1, 1, 0, 4'd0, 0, 0, 0, 0, 0, 8'd0);
        add(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 8'd0);
        add(1, 0, 1, 1, 0, 4'd0, 0, 1, 1, 0, 0, 8'd0);
        add(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1, 8'd1);
        add(1, 0, 1, 1, 0, 4'd0, 0, 1, 1, 0, 1, 8'd2);
        add(1, 0, 1, 1, 0, 4'd0, 0, 0, 0, 0, 1, 8'd3);
        add(1, 0, 1, 1, 0, 4'd0, 0, 1, 1, 0, 1, 8'd4);
        add(2, 0, 1, 1, 0, 4'd0, 0, 1, 1, 0, 1, 8'd5);
        // err_clr coinciding with an illegal edge, then err_clr alone.
        add(2, 0, 0, 0, 0, 4'd0, 0, 1, 1, 0, 1, 8'd5);
        add(1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1, 8'd5);
        add(1, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0, 1, 8'd1);
        add(1, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0, 0, 8'd0);

        foreach (vecs[i]) begin
            reset = vecs[i].rst; A = vecs[i].a; B = vecs[i].b; Z = vecs[i].z;
            filt_len = vecs[i].fl; err_clr = vecs[i].clr;
            step();
            check($sformatf("row%0d Af", i), 8'(Af), 8'(vecs[i].eaf));
            check($sformatf("row%0d Bf", i), 8'(Bf), 8'(vecs[i].ebf));
            check($sformatf("row%0d Zf", i), 8'(Zf), 8'(vecs[i].ezf));
            check($sformatf("row%0d err", i), 8'(err), 8'(vecs[i].eerr));
            check($sformatf("row%0d err_cnt", i), err_cnt, vecs[i].ecnt);
        end
        err_clr = 1'b0;

        // Saturation: 300 simultaneous toggles.
        for (int i = 1; i <= 300; i++) begin
            A = i[0]; B = i[0];
            step();
            if (i == 100) check("sat mid err_cnt", err_cnt, 8'd97);
        end
        for (int i = 0; i < 5; i++) step();
        check("sat err_cnt", err_cnt, 8'd255);
        check("sat err", 8'(err), 8'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("sat clr err_cnt", err_cnt, 8'd0);
        check("sat clr err", 8'(err), 8'd0);

        // Arming: both pins high through reset release.
        reset = 1'b1; A = 1'b1; B = 1'b1; filt_len = 4'd3;
        step(); step();
        check("arm reset err_cnt", err_cnt, 8'd0);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("arm rise%0d Af", k), 8'(Af), 8'(k >= 6));
            check($sformatf("arm rise%0d Bf", k), 8'(Bf), 8'(k >= 6));
            check($sformatf("arm rise%0d err", k), 8'(err), 8'd0);
        end
        A = 1'b0; B = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("arm fall%0d Af", k), 8'(Af), 8'(k < 6));
            check($sformatf("arm fall%0d err", k), 8'(err), 8'(k >= 7));
        end
        check("arm fall err_cnt", err_cnt, 8'd1);

        // Reset asserted with a pending edge discards all state.
        A = 1'b1; reset = 1'b1;
        step();
        check("midreset Af", 8'(Af), 8'd0);
        check("midreset err", 8'(err), 8'd0);
        check("midreset err_cnt", err_cnt, 8'd0);
        reset = 1'b0; A = 1'b0; filt_len = 4'd15;
        step(); step(); step();

        // filt_len shrink while the counter sits at 10.
        A = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("shrink wait%0d Af", k), 8'(Af), 8'd0);
        end
        filt_len = 4'd2;
        step();
        check("shrink Af", 8'(Af), 8'd1);
        A = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("shrink fall%0d Af", k), 8'(Af), 8'(k < 5));
        end

        // Zf latency with filt_len=7.
`ifdef QUAD_FILTER_Z_EN
        zlat = 10;
`else
        zlat = 2;
`endif
        filt_len = 4'd7; Z = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("zf%0d", k), 8'(Zf), 8'(k >= zlat));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
